// File: rtl/instruction_fetch_pkg.sv
// Core-wide constants and types shared by the IF stage.
//   XLEN            : datapath width
//   IF_NOP_INSTR    : addi x0,x0,0, used as the IF/ID bubble
//   IF_RESET_PC     : default reset vector
//   if_state_e      : fetch FSM states (FETCH / HOLD / DRAIN)
package instruction_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    HOLD  = 2'd1,  // decode stalled, one fetched word parked in the skid
    DRAIN = 2'd2   // redirected while a request was in flight; discard it
  } if_state_e;
endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instr, pc} buffer parking a fetched word while decode stalls.
//   clk, rst_n      : clock, synchronous active-low reset
//   i_load          : capture i_instr/i_pc, mark full
//   i_unload        : entry consumed, mark empty
//   i_clear         : flush (wins over load/unload)
//   o_full, o_instr, o_pc : entry state and contents
module if_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_full;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instruction_fetch.sv
// RV32I IF stage: owns the PC, fetches words over a req/ready handshake and
// fills the IF/ID register consumed by decode.
//   clk, rst_n               : clock, synchronous active-low reset
//   imem_req/addr            : fetch request (combinational from state/pc)
//   imem_ready/rdata         : transfer completes when req & ready
//   stall                    : decode cannot accept, hold a valid IF/ID entry
//   redirect/redirect_pc     : taken branch/jump, flush and refetch
//   IF_ID_IR/NPC/PC/valid    : registered IF/ID pipeline register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_NPC,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_valid
);
  if_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_pc_inc;
  // Address of the in-flight request being discarded; pc already holds the target.
  logic [31:0] r_drain_addr, w_drain_nxt;
  logic [31:0] r_ir, r_ipc, r_npc, w_ir_nxt, w_ipc_nxt, w_npc_nxt;
  logic        r_v, w_v_nxt;
  logic        w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
  logic [31:0] w_skid_instr, w_skid_pc;

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  assign w_pc_inc  = r_pc + 32'd4;
  // Request drops during reset so an abandoned transaction is not re-issued.
  assign imem_req  = rst_n && (r_state != HOLD);
  assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_drain_nxt   = r_drain_addr;
    w_ir_nxt      = r_ir;
    w_ipc_nxt     = r_ipc;
    w_npc_nxt     = r_npc;
    w_v_nxt       = r_v;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    if (redirect) begin
      // Redirect beats stall and everything else.
      w_pc_nxt     = redirect_pc & ~32'd3;
      w_v_nxt      = 1'b0;
      w_ir_nxt     = NOP_INSTR;
      w_skid_clear = 1'b1;
      unique case (r_state)
        FETCH: if (!imem_ready) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = r_pc;
        end
        HOLD:    w_state_nxt = FETCH;
        DRAIN:   w_state_nxt = DRAIN;
        default: w_state_nxt = FETCH;
      endcase
    end else begin
      unique case (r_state)
        FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = w_pc_inc;
            if (!stall || !r_v) begin
              w_ir_nxt  = imem_rdata;
              w_ipc_nxt = r_pc;
              w_npc_nxt = w_pc_inc;
              w_v_nxt   = 1'b1;
            end else begin
              w_skid_load = 1'b1;
              w_state_nxt = HOLD;
            end
          end else if (!stall) begin
            w_v_nxt  = 1'b0;
            w_ir_nxt = NOP_INSTR;
          end
        end
        HOLD: if (!stall) begin
          w_ir_nxt      = w_skid_instr;
          w_ipc_nxt     = w_skid_pc;
          w_npc_nxt     = w_skid_pc + 32'd4;
          w_v_nxt       = w_skid_full;
          w_skid_unload = 1'b1;
          w_state_nxt   = FETCH;
        end
        DRAIN: if (imem_ready) w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_ir         <= NOP_INSTR;
      r_ipc        <= '0;
      r_npc        <= '0;
      r_v          <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_nxt;
      r_ir         <= w_ir_nxt;
      r_ipc        <= w_ipc_nxt;
      r_npc        <= w_npc_nxt;
      r_v          <= w_v_nxt;
    end
  end

  assign IF_ID_IR    = r_ir;
  assign IF_ID_PC    = r_ipc;
  assign IF_ID_NPC   = r_npc;
  assign IF_ID_valid = r_v;
endmodule
